shift_tx_ctrl: RTL and testbench
================================

SHIFT_TX_CTRL -- requirements
Module: shift_tx_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of data bits per frame (legal range 2..32).
REQ-002 SHALL have parameter LSB_FIRST, default 1, meaning 1 = LSB shifted out first (right shift), 0 = MSB first.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port DATA_IN  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port LOAD_VALID  input  1  requester asserts that DATA_IN holds a valid word.
REQ-007 SHALL have port LOAD_READY  output  1  controller can accept a word this cycle.
REQ-008 SHALL have port DOUT  output  1  serial data bit.
REQ-009 SHALL have port DOUT_VALID  output  1  DOUT carries a frame bit this cycle.
REQ-010 SHALL have port BUSY  output  1  a frame is in progress.
REQ-011 SHALL have port DONE  output  1  one-cycle pulse at frame completion.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT, PARITY (present only with the macro) and DONE, all registered.
REQ-013 SHALL assert LOAD_READY only in IDLE and SHALL hold it low in every other state.
REQ-014 SHALL accept a word on an edge where LOAD_VALID and LOAD_READY are both 1, capture DATA_IN into an internal WIDTH-bit shift register, clear the bit counter and enter SHIFT.
REQ-015 SHALL ignore LOAD_VALID and DATA_IN in every state other than IDLE; words presented while busy are not queued.
REQ-016 SHALL hold DOUT_VALID=1 in SHIFT for exactly WIDTH consecutive cycles beginning the cycle after the accepting edge, presenting one data bit per cycle.
REQ-017 SHALL drive DOUT from bit 0 and shift right when LSB_FIRST=1; it SHALL drive DOUT from bit WIDTH-1 and shift left when LSB_FIRST=0; vacated positions fill with 0.
REQ-018 SHALL use a bit counter of width clog2(WIDTH) that leaves SHIFT when it reaches WIDTH-1, with no wrap-around or extra bit.
REQ-019 SHALL drive DOUT=0 and DOUT_VALID=0 whenever no frame bit is being presented.
REQ-020 SHALL pass through DONE for exactly one cycle with DONE=1, DOUT_VALID=0 and LOAD_READY=0, then return to IDLE.
REQ-021 SHALL assert BUSY in SHIFT, PARITY and DONE, and deassert it in IDLE.
REQ-022 SHALL give a minimum frame period of WIDTH+2 cycles (WIDTH+3 with parity) when LOAD_VALID is held high continuously.

Reset
REQ-023 SHALL, when RST=1 at a rising edge, enter IDLE and clear the shift register and bit counter, with LOAD_READY=1 and DOUT, DOUT_VALID, BUSY and DONE all 0 from the following cycle.
REQ-024 SHALL let RST override every other input in the same cycle, including a simultaneous LOAD_VALID.
REQ-025 SHALL, on a reset during SHIFT or PARITY, abort the frame with no DONE pulse and no further DOUT_VALID.

Configuration
REQ-026 SHALL, when macro SHIFT_TX_CTRL_PARITY_EN is defined, enter PARITY after the last data bit for one cycle, with DOUT equal to the even parity (XOR) of the captured word and DOUT_VALID=1, then go to DONE.
REQ-027 SHALL, when SHIFT_TX_CTRL_PARITY_EN is undefined, have no PARITY state and no parity logic, and go from SHIFT directly to DONE.

Verification
REQ-028 SHALL cover: WIDTH=8, LSB_FIRST=1, load 0xA5 -> DOUT 1,0,1,0,0,1,0,1 on cycles 1-8 with DOUT_VALID=1, DONE=1 on cycle 9, LOAD_READY=1 on cycle 10.
REQ-029 SHALL cover: LSB_FIRST=0, load 0x0F -> DOUT 0,0,0,0,1,1,1,1, then DONE on cycle 9.
REQ-030 SHALL cover: parity macro defined, load 0x07 -> eight data bits, then parity bit DOUT=1 on cycle 9, DONE on cycle 10; load 0x03 -> parity bit 0.
REQ-031 SHALL cover: LOAD_VALID pulsed with 0xFF on cycle 4 of a 0x00 frame -> DOUT stays 0 for the whole frame and no second frame starts.
REQ-032 SHALL cover: RST=1 on cycle 3 of a frame -> IDLE on the next cycle, DOUT_VALID=0, DONE never pulses, LOAD_READY=1.
REQ-033 SHALL cover: LOAD_VALID held at 1 with WIDTH=8 and no parity -> accepting edges exactly 10 cycles apart and one DONE per frame.

Source files
------------

// File: rtl/shift_tx_ctrl.sv
// Parallel-to-serial transmit controller: loads a WIDTH-bit word on a
// valid/ready handshake and shifts it out one bit per cycle, then pulses DONE.
// Define SHIFT_TX_CTRL_PARITY_EN to append an even-parity bit after the data bits.
module shift_tx_ctrl #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    output logic             DOUT,
    output logic             DOUT_VALID,
    output logic             BUSY,
    output logic             DONE
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef SHIFT_TX_CTRL_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_DONE   = 2'd2,
        S_PARITY = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_q;
    logic [CW-1:0]    bit_cnt;
    logic             accept;

`ifdef SHIFT_TX_CTRL_PARITY_EN
    logic             parity_q;
`endif

    assign accept = LOAD_VALID && (state == S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (accept) state_nxt = S_SHIFT;
`ifdef SHIFT_TX_CTRL_PARITY_EN
            S_SHIFT:  if (bit_cnt == LAST) state_nxt = S_PARITY;
            S_PARITY: state_nxt = S_DONE;
`else
            S_SHIFT:  if (bit_cnt == LAST) state_nxt = S_DONE;
`endif
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // The counter saturates at LAST; it is cleared again on the next accept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_q <= '0;
            bit_cnt <= '0;
`ifdef SHIFT_TX_CTRL_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (accept) begin
            shift_q <= DATA_IN;
            bit_cnt <= '0;
`ifdef SHIFT_TX_CTRL_PARITY_EN
            parity_q <= ^DATA_IN;
`endif
        end else if (state == S_SHIFT) begin
            shift_q <= LSB_FIRST ? {1'b0, shift_q[WIDTH-1:1]}
                                 : {shift_q[WIDTH-2:0], 1'b0};
            if (bit_cnt != LAST) begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        LOAD_READY = 1'b0;
        DOUT       = 1'b0;
        DOUT_VALID = 1'b0;
        BUSY       = 1'b1;
        DONE       = 1'b0;
        unique case (state)
            S_IDLE: begin
                LOAD_READY = 1'b1;
                BUSY       = 1'b0;
            end
            S_SHIFT: begin
                DOUT_VALID = 1'b1;
                DOUT       = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
            end
`ifdef SHIFT_TX_CTRL_PARITY_EN
            S_PARITY: begin
                DOUT_VALID = 1'b1;
                DOUT       = parity_q;
            end
`endif
            S_DONE:  DONE = 1'b1;
            default: BUSY = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Bench for shift_tx_ctrl: an LSB-first and an MSB-first instance share one
// stimulus stream and are compared every cycle against a frame-queue model.
module tb_shift_tx_ctrl;

    localparam int W = 8;
`ifdef SHIFT_TX_CTRL_PARITY_EN
    localparam int DONE_CYC = W + 2;
`else
    localparam int DONE_CYC = W + 1;
`endif
    localparam int PERIOD = DONE_CYC + 1;

    typedef struct packed {
        logic ready;
        logic valid;
        logic dout;
        logic busy;
        logic done;
    } out_t;

    localparam out_t IDLE_OUT = '{ready: 1'b1, valid: 1'b0, dout: 1'b0, busy: 1'b0, done: 1'b0};

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] DATA_IN;
    logic         LOAD_VALID;
    logic [1:0]   lr, dv, dout, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    shift_tx_ctrl #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .LOAD_VALID(LOAD_VALID),
        .LOAD_READY(lr[0]), .DOUT(dout[0]), .DOUT_VALID(dv[0]),
        .BUSY(busy[0]), .DONE(done[0])
    );

    shift_tx_ctrl #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .LOAD_VALID(LOAD_VALID),
        .LOAD_READY(lr[1]), .DOUT(dout[1]), .DOUT_VALID(dv[1]),
        .BUSY(busy[1]), .DONE(done[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each accepted word becomes a queue of expected per-cycle outputs
    // (data bits in transmit order, optional parity bit, one DONE cycle).
    out_t q0[$];
    out_t q1[$];
    out_t cur[2];
    bit   model_live = 1'b0;

    function automatic void build_frame(input bit lsb, input logic [W-1:0] w, ref out_t q[$]);
        out_t e;
        for (int i = 0; i < W; i++) begin
            e = '{ready: 1'b0, valid: 1'b1, dout: (lsb ? w[i] : w[W-1-i]), busy: 1'b1, done: 1'b0};
            q.push_back(e);
        end
`ifdef SHIFT_TX_CTRL_PARITY_EN
        e = '{ready: 1'b0, valid: 1'b1, dout: ^w, busy: 1'b1, done: 1'b0};
        q.push_back(e);
`endif
        e = '{ready: 1'b0, valid: 1'b0, dout: 1'b0, busy: 1'b1, done: 1'b1};
        q.push_back(e);
    endfunction

    always @(posedge CLK) begin
        out_t n0, n1;
        if (RST) begin
            q0.delete();
            q1.delete();
            n0 = IDLE_OUT;
            n1 = IDLE_OUT;
            model_live <= 1'b1;
        end else begin
            if (cur[0].ready && LOAD_VALID) build_frame(1'b1, DATA_IN, q0);
            if (cur[1].ready && LOAD_VALID) build_frame(1'b0, DATA_IN, q1);
            n0 = (q0.size() > 0) ? q0.pop_front() : IDLE_OUT;
            n1 = (q1.size() > 0) ? q1.pop_front() : IDLE_OUT;
        end
        cur[0] <= n0;
        cur[1] <= n1;
    end

    always @(negedge CLK) begin
        if (model_live) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dut%0d_ready", k), lr[k],   cur[k].ready);
                check($sformatf("dut%0d_valid", k), dv[k],   cur[k].valid);
                check($sformatf("dut%0d_dout",  k), dout[k], cur[k].dout);
                check($sformatf("dut%0d_busy",  k), busy[k], cur[k].busy);
                check($sformatf("dut%0d_done",  k), done[k], cur[k].done);
            end
        end
    end

    // One word through both instances; records the serial bits in arrival
    // order (bit i = i-th bit out), the bit after the data, and DONE/READY timing.
    task automatic frame(input logic [W-1:0] w, output logic [W-1:0] s0, output logic [W-1:0] s1,
                         output logic p, output logic pv, output int done_at, output int ready_at);
        done_at  = 0;
        ready_at = 0;
        s0 = '0;
        s1 = '0;
        p  = 1'b0;
        pv = 1'b0;
        @(negedge CLK);
        DATA_IN    = w;
        LOAD_VALID = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            LOAD_VALID = 1'b0;
            if (i <= W) begin
                s0[i-1] = dout[0];
                s1[i-1] = dout[1];
            end
            if (i == W + 1) begin
                p  = dout[0];
                pv = dv[0];
            end
            if (done_at != 0 && ready_at == 0 && lr[0]) ready_at = i;
            if (done[0] && done_at == 0) done_at = i;
        end
    endtask

    initial begin
        logic [W-1:0] s0, s1;
        logic         p, pv;
        int           d_at, r_at, ones, dones, late_valid;
        int           acc[$];

        RST        = 1'b1;
        LOAD_VALID = 1'b1;
        DATA_IN    = 8'hFF;
        repeat (3) @(negedge CLK);
        RST        = 1'b0;
        LOAD_VALID = 1'b0;
        DATA_IN    = '0;

        check("reset_ready", lr,   2'b11);
        check("reset_valid", dv,   2'b00);
        check("reset_dout",  dout, 2'b00);
        check("reset_busy",  busy, 2'b00);
        check("reset_done",  done, 2'b00);

        frame(8'hA5, s0, s1, p, pv, d_at, r_at);
        check("a5_lsb_bits", s0, 8'hA5);
        check("a5_msb_bits", s1, 8'hA5);
        check("a5_done_cycle", d_at, DONE_CYC);
        check("a5_ready_cycle", r_at, DONE_CYC + 1);

        frame(8'h0F, s0, s1, p, pv, d_at, r_at);
        check("0f_lsb_bits", s0, 8'h0F);
        check("0f_msb_bits", s1, 8'hF0);
        check("0f_done_cycle", d_at, DONE_CYC);

        frame(8'h07, s0, s1, p, pv, d_at, r_at);
        check("07_lsb_bits", s0, 8'h07);
`ifdef SHIFT_TX_CTRL_PARITY_EN
        check("07_parity_bit", p, 1'b1);
        check("07_parity_valid", pv, 1'b1);
`else
        check("07_after_data_valid", pv, 1'b0);
`endif
        frame(8'h03, s0, s1, p, pv, d_at, r_at);
        check("03_msb_bits", s1, 8'hC0);
`ifdef SHIFT_TX_CTRL_PARITY_EN
        check("03_parity_bit", p, 1'b0);
        check("03_parity_valid", pv, 1'b1);
`else
        check("03_after_data_valid", pv, 1'b0);
`endif

        // Word offered mid-frame must be dropped, not queued.
        @(negedge CLK);
        DATA_IN    = 8'h00;
        LOAD_VALID = 1'b1;
        ones  = 0;
        dones = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge CLK);
            LOAD_VALID = (i == 4);
            DATA_IN    = (i == 4) ? 8'hFF : 8'h00;
            ones  += int'(dout[0]) + int'(dout[1]);
            dones += int'(done[0]);
        end
        LOAD_VALID = 1'b0;
        check("busy_ignore_ones", ones, 0);
        check("busy_ignore_dones", dones, 1);
        check("busy_ignore_idle", lr, 2'b11);

        // Reset during the third data bit aborts the frame.
        @(negedge CLK);
        DATA_IN    = 8'hFF;
        LOAD_VALID = 1'b1;
        dones      = 0;
        late_valid = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge CLK);
            LOAD_VALID = 1'b0;
            RST        = (i == 3);
            if (i == 4) begin
                check("abort_ready", lr, 2'b11);
                check("abort_valid", dv, 2'b00);
            end
            if (i >= 4) late_valid += int'(dv[0]) + int'(dv[1]);
            dones += int'(done[0]) + int'(done[1]);
        end
        check("abort_no_done", dones, 0);
        check("abort_no_valid", late_valid, 0);

        // LOAD_VALID held high: accepts must be one frame period apart.
        @(negedge CLK);
        DATA_IN    = 8'h3C;
        LOAD_VALID = 1'b1;
        dones      = 0;
        for (int c = 0; c < 35; c++) begin
            if (lr[0]) acc.push_back(c);
            dones += int'(done[0]);
            @(negedge CLK);
        end
        LOAD_VALID = 1'b0;
        check("stream_accepts", acc.size(), 4);
        if (acc.size() >= 3) begin
            check("stream_gap1", acc[1] - acc[0], PERIOD);
            check("stream_gap2", acc[2] - acc[1], PERIOD);
        end
        check("stream_dones", dones, 3);
        repeat (15) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
